// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter between two masters for the external SRAM controller port.
// It turns each granted transaction into an address strobe, plus a data strobe for writes.
module sram_port_arbiter #(
    parameter int WAIT = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0,
    input  logic        we0,
    input  logic [15:0] addr0,
    input  logic [15:0] wdata0,
    output logic        ack0,
    output logic [15:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata1,
    output logic        ack1,
    output logic [15:0] rdata1,
    output logic [15:0] mem_in,
    output logic        mem_writeA,
    output logic        mem_writeD,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        grant
);

    localparam int CNT_W = $clog2(WAIT + 1);
    localparam logic [CNT_W-1:0] A_TC    = CNT_W'(WAIT);
    localparam logic [CNT_W-1:0] D_TC    = CNT_W'(WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_AWAIT = 2'd1;
    localparam logic [1:0] S_DWAIT = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [15:0]      mem_in_q, mem_in_d;
    logic             mem_writeA_q, mem_writeA_d;
    logic             mem_writeD_q, mem_writeD_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic [15:0]      rdata0_q, rdata0_d;
    logic [15:0]      rdata1_q, rdata1_d;
    logic             pick;

    // A tie goes to the port that did not win last time.
    always_comb begin
        pick = (req0 && req1) ? ~last_grant_q : req1;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_in_d     = mem_in_q;
        mem_writeA_d = 1'b0;
        mem_writeD_d = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    we_d         = pick ? we1 : we0;
                    wdata_d      = pick ? wdata1 : wdata0;
                    mem_in_d     = pick ? addr1 : addr0;
                    mem_writeA_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_AWAIT;
                end
            end
            S_AWAIT: begin
                if (cnt_q == A_TC) begin
                    cnt_d = '0;
                    if (we_q) begin
                        mem_in_d     = wdata_q;
                        mem_writeD_d = 1'b1;
                        state_d      = S_DWAIT;
                    end else begin
                        // The controller's data register is settled by now.
                        if (grant_q) begin
                            rdata1_d = mem_rdata;
                            ack1_d   = 1'b1;
                        end else begin
                            rdata0_d = mem_rdata;
                            ack0_d   = 1'b1;
                        end
                        state_d = S_ACK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DWAIT: begin
                if (cnt_q == D_TC) begin
                    cnt_d   = '0;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_in_q     <= '0;
            mem_writeA_q <= 1'b0;
            mem_writeD_q <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_in_q     <= mem_in_d;
            mem_writeA_q <= mem_writeA_d;
            mem_writeD_q <= mem_writeD_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign mem_in     = mem_in_q;
    assign mem_writeA = mem_writeA_q;
    assign mem_writeD = mem_writeD_q;
    assign grant      = grant_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester round-robin arbiter and sequencer for the external 16-bit SRAM controller port. It accepts whole read and write transactions over per-port req/ack handshakes. It converts each transaction into the controller's strobe sequence:

- address load on `mem_writeA`,
- then, for writes only, a data strobe on `mem_writeD`.

It also returns read data captured from the controller's data register. It sits between the CPU/loader masters and the SRAM controller, and it is the only agent that drives the controller's strobes.

## Interface
- `WAIT`, default 3: cycles from a controller strobe until the controller is idle again. Legal values are 3 or more. For reads, the controller's data register is valid once this many cycles have elapsed.
- `clk` input 1: clock. Everything is on the rising edge.
- `rstn` input 1: reset, synchronous, active-low.
- `req0`, `req1` input 1: transaction request. It stays high until the matching ack.
- `we0`, `we1` input 1: 1 = write, 0 = read. Sampled at grant.
- `addr0`, `addr1` input 16: word address. Sampled at grant.
- `wdata0`, `wdata1` input 16: write data. Sampled at grant.
- `ack0`, `ack1` output 1: one-cycle completion pulse.
- `rdata0`, `rdata1` output 16: read data. Valid in the ack cycle, held until the next read ack on that port.
- `mem_in` output 16: address or data driven to the controller.
- `mem_writeA` output 1: one-cycle address-load strobe.
- `mem_writeD` output 1: one-cycle data-write strobe.
- `mem_rdata` input 16: the controller's captured data register.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `grant` output 1: index of the port that owns the current or most recent transaction.

## Operation
FSM states:

- **IDLE**
  - No request: stay in IDLE.
  - Any request: select a port, latch `we`/`addr`/`wdata`, set `grant`, load `mem_in` with the address, and register `mem_writeA` = 1. Go to AWAIT.
- **AWAIT**
  - Wait counter runs from 1 to `WAIT`. `mem_writeA` is high only in the first AWAIT cycle.
  - At terminal count on a read: capture `mem_rdata` into the granted port's `rdata`, then go to ACK.
  - At terminal count on a write: load `mem_in` with the latched wdata, register `mem_writeD` = 1, then go to DWAIT.
- **DWAIT**
  - Wait counter runs from 1 to `WAIT-1`. `mem_writeD` is high only in the first DWAIT cycle.
  - At terminal count, go to ACK.
- **ACK**
  - `ack` of the granted port is high for exactly one cycle, then go to IDLE.

Arbitration rules:

- Only one request: that port wins.
- Both requesting: the port opposite `last_grant` wins. `last_grant` is updated at each grant.
- After reset, `last_grant` = 1, so port 0 wins the first tie.

Handshake and other rules:

- A requester must drop `req` in the cycle after its ack. IDLE in that cycle sees only the other port.
- Changes to `addr`, `we` or `wdata` after grant are ignored.
- `mem_writeA` and `mem_writeD` are never high in the same cycle.
- `mem_in` holds its value between strobes.
- `rdata` of the port that was not granted never changes.

## Timing
Cycle 0 is the IDLE cycle in which `req` is first seen high.

- Read: `mem_writeA` is high in cycle 1. `mem_rdata` is sampled at the end of cycle 1+WAIT. Ack and `rdata` appear in cycle 2+WAIT, which is cycle 5 at default.
- Write: `mem_writeA` is high in cycle 1 and `mem_writeD` is high in cycle 2+WAIT. Ack appears in cycle 2+2·WAIT, which is cycle 8 at default.
- The earliest next grant is in the cycle after ack+1. This guarantees at least `WAIT` cycles between any two controller strobes.
- Reset values: all outputs are 0, the FSM is in IDLE, the counter is 0 and `last_grant` = 1.
- Reset mid-transaction: the FSM returns to IDLE on the next edge. No ack is issued and both strobes go low. The requester must reissue.
- A request arriving while `busy`: it is held off with no ack until IDLE. It is then arbitrated normally.

## Test plan
- **Reset values:** hold `rstn` = 0 for 3 cycles with `req0` = 1 → all outputs are 0 and no strobe. After release, the first grant goes to port 0 and `mem_writeA` is seen in cycle 1.
- **Single read:** port 0 reads address 0x1234, with the controller model returning 0xBEEF → `mem_in` = 0x1234 and `mem_writeA` in cycle 1. `ack0` and `rdata0` = 0xBEEF in cycle 5. `rdata1` is unchanged.
- **Single write:** port 1 writes 0xA5A5 to 0x0042 → `mem_writeA` with `mem_in` = 0x0042 in cycle 1. `mem_writeD` with `mem_in` = 0xA5A5 in cycle 5. `ack1` in cycle 8. A read-back of 0x0042 returns 0xA5A5.
- **Round-robin:** `req0` and `req1` held continuously, each dropping only for the cycle after its ack → grants alternate 0,1,0,1. Every strobe pair is at least 3 cycles apart.
- **Stability and no overlap:** change `addr0` and `wdata0` every cycle after grant → the transaction uses the values sampled at grant. `mem_writeA` and `mem_writeD` are never high together.
- **Reset mid-write:** assert `rstn` = 0 in cycle 3 of a write → no `mem_writeD` and no ack. `busy` = 0 on the next edge. The reissued request completes normally.
